regfile_wb_ctrl: RTL and testbench
==================================

Name: regfile_wb_ctrl

Overview:
- Write-back controller and hazard scoreboard for the integer architectural register file (2 read ports, 1 write port).
- Arbitrates two write-back requesters, the ALU (req 0) and the LSU (req 1), onto the single register-file write port. Uses a round-robin policy.
- Tracks in-flight destination registers in a 32-entry busy scoreboard.
- Drives the decoder stall for RAW/WAW hazards and for same-cycle read/write address conflicts on the register file.

Parameters:
- XLEN, 32, data width of the write-back path.
- AW, 5, register address width.
- RR_INIT, 0, requester holding round-robin priority after reset (0 = ALU, 1 = LSU).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- iss_valid  in  1  decoder issuing an instruction this cycle
- iss_has_rd  in  1  the issued instruction writes a destination register
- iss_rd  in  AW  destination register of the issued instruction
- rs_re_p0 / rs_re_p1  in  1  decoder source-read enables
- rs_addr_p0 / rs_addr_p1  in  AW  decoder source addresses
- stall_dec  out  1  decoder must hold; issue is not accepted this cycle
- wb0_valid, wb0_rd, wb0_data  in  1/AW/XLEN  ALU write-back request
- wb0_ready  out  1  ALU request accepted this cycle
- wb1_valid, wb1_rd, wb1_data  in  1/AW/XLEN  LSU write-back request
- wb1_ready  out  1  LSU request accepted this cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  XLEN  register-file write data
- busy_vec  out  32  scoreboard state, for debug and bench visibility

Interface decision:
- One clock, clk; reset is synchronous and active-high, named reset; all state updates on posedge clk.

Behaviour:
- Reset values: busy_vec=0, rf_we=0, rf_waddr=0, rf_wdata=0, rr_ptr=RR_INIT. Reset mid-operation drops any in-flight write; pending requests are re-arbitrated after reset deasserts.
- Handshake: valid/ready. A requester holds valid, rd and data stable until its ready is seen high. wbN_ready is combinational from the valids and rr_ptr.
- Arbitration:
  - One grant per cycle.
  - If both requesters are valid, grant goes to the one selected by rr_ptr; rr_ptr then flips to the other requester.
  - If only one is valid, it is granted and rr_ptr is unchanged.
- Write latency: a request accepted in cycle N produces rf_we=1 with its rf_waddr/rf_wdata in cycle N+1 (outputs registered). With no grant, rf_we=0 and rf_waddr is driven to 0.
- Writes to x0 are accepted (ready=1) but rf_we stays 0. x0 is never marked busy.
- Scoreboard:
  - Set busy[iss_rd] when iss_valid & iss_has_rd & !stall_dec & iss_rd!=0.
  - Clear busy[rd] in the cycle the registered write appears (rf_we=1).
  - Set and clear on the same index in the same cycle: set wins.
- stall_dec = iss_valid & (H_raw | H_waw | H_port):
  - H_raw: (rs_re_p0 & busy[rs_addr_p0]) | (rs_re_p1 & busy[rs_addr_p1]), with x0 excluded.
  - H_waw: iss_has_rd & busy[iss_rd].
  - H_port: rf_we & ((rs_re_p0 & rs_addr_p0==rf_waddr) | (rs_re_p1 & rs_addr_p1==rf_waddr)). The register file suppresses a read whose address equals the write address, so the decoder retries in the next cycle.
- Write-back for a register that is not busy is still written; it does not clear other bits.
- Both requesters valid for the same rd: they serialize in grant order; the bit clears on the first write.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - Adds outputs fwd_hit_p0 / fwd_hit_p1 (1 bit each) and fwd_data (XLEN).
  - When rf_we & rs_addr_pX==rf_waddr, assert fwd_hit_pX and drive fwd_data=rf_wdata. That source's H_port and H_raw contributions are masked.
  - The decoder muxes fwd_data in place of the register-file output.
- Undefined: no forwarding ports exist; the stall rules above apply unchanged.

Decomposition:
- Shared package/header: AW, XLEN, the register index constants (reuse the existing register define header), and the requester ID encoding (REQ_ALU=0, REQ_LSU=1).
- Sub-module rr_arb2: 2-requester round-robin arbiter with grant vector and pointer update. Everything else (scoreboard, output register, hazard logic) stays in regfile_wb_ctrl.

Test Plan:
- Reset: after reset with all inputs 0 -> busy_vec=0, rf_we=0, stall_dec=0, wb0_ready=wb1_ready=0.
- Single write: issue rd=5; ALU wb0 {rd=5, data=0xDEADBEEF} in cycle N -> wb0_ready=1 at N, rf_we=1/addr=5/data=0xDEADBEEF at N+1, busy[5] 1->0 at N+2.
- Contention: both requesters valid every cycle for rd 7 (ALU) and rd 9 (LSU), RR_INIT=0 -> grants alternate ALU,LSU,ALU; rf_waddr sequence 7,9,7.
- RAW stall: busy[3]=1; issue reading rs_addr_p0=3 -> stall_dec=1 until the write to 3 commits. Without the bypass macro, stall also holds during the rf_we cycle; with it, fwd_hit_p0=1 in that cycle.
- WAW and x0: issue rd=4 twice back-to-back -> second stalls until x4 retires; a write-back to rd=0 -> ready=1, rf_we=0, busy_vec unchanged.
- Reset mid-flight: reset asserted while busy_vec=0x28 and rf_we=1 -> next cycle busy_vec=0 and rf_we=0; rr_ptr returns to RR_INIT.

Source files
------------

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared constants for the register-file write-back controller: widths,
// register indices and write-back requester IDs.
package regfile_wb_ctrl_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int NREGS    = 32;

  localparam logic [AW_DEF-1:0] REG_X0 = '0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

// File: rtl/regfile_wb_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter. The pointer names the requester that
// wins a tie and flips only when both requesters are contending.
module rr_arb2
  import regfile_wb_ctrl_pkg::*;
#(
  parameter req_id_e RR_INIT = REQ_ALU
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (ptr == REQ_LSU) ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr <= RR_INIT;
    else if (req == 2'b11) ptr <= (ptr == REQ_ALU) ? REQ_LSU : REQ_ALU;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back arbitration, busy scoreboard and decoder stall generation.
// Optional macro REGFILE_WB_BYPASS_EN adds forwarding of the registered write.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int AW      = AW_DEF,
  parameter bit RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iss_valid,
  input  logic             iss_has_rd,
  input  logic [AW-1:0]    iss_rd,
  input  logic             rs_re_p0,
  input  logic             rs_re_p1,
  input  logic [AW-1:0]    rs_addr_p0,
  input  logic [AW-1:0]    rs_addr_p1,
  output logic             stall_dec,
  input  logic             wb0_valid,
  input  logic [AW-1:0]    wb0_rd,
  input  logic [XLEN-1:0]  wb0_data,
  output logic             wb0_ready,
  input  logic             wb1_valid,
  input  logic [AW-1:0]    wb1_rd,
  input  logic [XLEN-1:0]  wb1_data,
  output logic             wb1_ready,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [NREGS-1:0] busy_vec
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic             fwd_hit_p0,
  output logic             fwd_hit_p1,
  output logic [XLEN-1:0]  fwd_data
`endif
);

  logic [1:0]       req;
  logic [1:0]       gnt;
  logic [AW-1:0]    sel_rd;
  logic [XLEN-1:0]  sel_data;
  logic             do_write;
  logic             raw_p0, raw_p1, port_p0, port_p1;
  logic             src_hz_p0, src_hz_p1, waw;
  logic             iss_set;
  logic [NREGS-1:0] busy_next;

  // Nothing is accepted while reset is held, so pending requests re-arbitrate after it.
  assign req = {wb1_valid, wb0_valid} & {2{~reset}};

  rr_arb2 #(.RR_INIT(req_id_e'(RR_INIT))) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign wb0_ready = gnt[0];
  assign wb1_ready = gnt[1];
  assign sel_rd    = gnt[1] ? wb1_rd   : wb0_rd;
  assign sel_data  = gnt[1] ? wb1_data : wb0_data;
  assign do_write  = (|gnt) && (sel_rd != REG_X0);

  assign raw_p0  = rs_re_p0 && (rs_addr_p0 != REG_X0) && busy_vec[rs_addr_p0];
  assign raw_p1  = rs_re_p1 && (rs_addr_p1 != REG_X0) && busy_vec[rs_addr_p1];
  assign port_p0 = rf_we && rs_re_p0 && (rs_addr_p0 == rf_waddr);
  assign port_p1 = rf_we && rs_re_p1 && (rs_addr_p1 == rf_waddr);

`ifdef REGFILE_WB_BYPASS_EN
  assign fwd_hit_p0 = rf_we && (rs_addr_p0 == rf_waddr);
  assign fwd_hit_p1 = rf_we && (rs_addr_p1 == rf_waddr);
  assign fwd_data   = rf_wdata;
  assign src_hz_p0  = (raw_p0 || port_p0) && !fwd_hit_p0;
  assign src_hz_p1  = (raw_p1 || port_p1) && !fwd_hit_p1;
`else
  assign src_hz_p0  = raw_p0 || port_p0;
  assign src_hz_p1  = raw_p1 || port_p1;
`endif

  assign waw       = iss_has_rd && (iss_rd != REG_X0) && busy_vec[iss_rd];
  assign stall_dec = iss_valid && (src_hz_p0 || src_hz_p1 || waw);
  assign iss_set   = iss_valid && iss_has_rd && !stall_dec && (iss_rd != REG_X0);

  // Set is applied after clear so a same-cycle set on the retiring index wins.
  always_comb begin
    busy_next = busy_vec;
    if (rf_we) busy_next[rf_waddr] = 1'b0;
    if (iss_set) busy_next[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_vec <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      busy_vec <= busy_next;
      rf_we    <= do_write;
      rf_waddr <= do_write ? sel_rd : '0;
      rf_wdata <= do_write ? sel_data : '0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: cycle table plus hand-written RAW,
// port-conflict, WAW/set-wins and mid-flight reset sequences.
module tb_regfile_wb_ctrl;

  logic        clk;
  logic        reset;
  logic        iss_valid, iss_has_rd;
  logic [4:0]  iss_rd;
  logic        rs_re_p0, rs_re_p1;
  logic [4:0]  rs_addr_p0, rs_addr_p1;
  logic        stall_dec;
  logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
  logic [4:0]  wb0_rd, wb1_rd;
  logic [31:0] wb0_data, wb1_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_vec;
`ifdef REGFILE_WB_BYPASS_EN
  logic        fwd_hit_p0, fwd_hit_p1;
  logic [31:0] fwd_data;
`endif

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_ctrl #(.XLEN(32), .AW(5), .RR_INIT(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .iss_valid  (iss_valid),
    .iss_has_rd (iss_has_rd),
    .iss_rd     (iss_rd),
    .rs_re_p0   (rs_re_p0),
    .rs_re_p1   (rs_re_p1),
    .rs_addr_p0 (rs_addr_p0),
    .rs_addr_p1 (rs_addr_p1),
    .stall_dec  (stall_dec),
    .wb0_valid  (wb0_valid),
    .wb0_rd     (wb0_rd),
    .wb0_data   (wb0_data),
    .wb0_ready  (wb0_ready),
    .wb1_valid  (wb1_valid),
    .wb1_rd     (wb1_rd),
    .wb1_data   (wb1_data),
    .wb1_ready  (wb1_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy_vec   (busy_vec)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .fwd_hit_p0 (fwd_hit_p0),
    .fwd_hit_p1 (fwd_hit_p1),
    .fwd_data   (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv, ih;
    logic [4:0]  ird;
    logic        re0;
    logic [4:0]  a0;
    logic        re1;
    logic [4:0]  a1;
    logic        v0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic        e_stall, e_r0, e_r1, e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    iss_valid = 0; iss_has_rd = 0; iss_rd = 0;
    rs_re_p0 = 0; rs_addr_p0 = 0; rs_re_p1 = 0; rs_addr_p1 = 0;
    wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
    wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic has_rd, input logic [4:0] rd,
                       input logic re0, input logic [4:0] a0,
                       input logic re1, input logic [4:0] a1);
    iss_valid = 1; iss_has_rd = has_rd; iss_rd = rd;
    rs_re_p0 = re0; rs_addr_p0 = a0; rs_re_p1 = re1; rs_addr_p1 = a1;
  endtask

  initial begin
    //          iv ih ird re0 a0 re1 a1 v0 rd0 d0            v1 rd1 d1            st r0 r1 we wa  wdata          busy
    vecs[0]  = '{0, 0, 0,  0, 0, 0, 0,  0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 0, 0,  32'h0,        32'h0};
    vecs[1]  = '{1, 1, 5,  0, 0, 0, 0,  0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 0, 0,  32'h0,        32'h0};
    vecs[2]  = '{0, 0, 0,  0, 0, 0, 0,  1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        0, 1, 0, 0, 0,  32'h0,        32'h20};
    vecs[3]  = '{0, 0, 0,  0, 0, 0, 0,  0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 1, 5,  32'hDEADBEEF, 32'h20};
    vecs[4]  = '{0, 0, 0,  0, 0, 0, 0,  0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 0, 0,  32'h0,        32'h0};
    vecs[5]  = '{0, 0, 0,  0, 0, 0, 0,  1, 7,  32'h11111111, 1, 9,  32'h22222222, 0, 1, 0, 0, 0,  32'h0,        32'h0};
    vecs[6]  = '{0, 0, 0,  0, 0, 0, 0,  1, 7,  32'h33333333, 1, 9,  32'h22222222, 0, 0, 1, 1, 7,  32'h11111111, 32'h0};
    vecs[7]  = '{0, 0, 0,  0, 0, 0, 0,  1, 7,  32'h33333333, 1, 9,  32'h44444444, 0, 1, 0, 1, 9,  32'h22222222, 32'h0};
    vecs[8]  = '{0, 0, 0,  0, 0, 0, 0,  0, 0,  32'h0,        1, 9,  32'h44444444, 0, 0, 1, 1, 7,  32'h33333333, 32'h0};
    vecs[9]  = '{0, 0, 0,  0, 0, 0, 0,  1, 0,  32'h55555555, 0, 0,  32'h0,        0, 1, 0, 1, 9,  32'h44444444, 32'h0};
    vecs[10] = '{0, 0, 0,  0, 0, 0, 0,  1, 10, 32'h66666666, 1, 11, 32'h77777777, 0, 0, 1, 0, 0,  32'h0,        32'h0};
    vecs[11] = '{0, 0, 0,  0, 0, 0, 0,  1, 10, 32'h66666666, 0, 0,  32'h0,        0, 1, 0, 1, 11, 32'h77777777, 32'h0};
    vecs[12] = '{1, 1, 0,  0, 0, 0, 0,  0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 1, 10, 32'h66666666, 32'h0};
    vecs[13] = '{0, 0, 0,  0, 0, 0, 0,  0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 0, 0,  32'h0,        32'h0};

    idle();
    reset = 1;
    step();
    step();
    reset = 0;

    for (int i = 0; i < 14; i++) begin
      iss_valid = vecs[i].iv; iss_has_rd = vecs[i].ih; iss_rd = vecs[i].ird;
      rs_re_p0 = vecs[i].re0; rs_addr_p0 = vecs[i].a0;
      rs_re_p1 = vecs[i].re1; rs_addr_p1 = vecs[i].a1;
      wb0_valid = vecs[i].v0; wb0_rd = vecs[i].rd0; wb0_data = vecs[i].d0;
      wb1_valid = vecs[i].v1; wb1_rd = vecs[i].rd1; wb1_data = vecs[i].d1;
      @(negedge clk);
      chk($sformatf("vec%0d stall_dec", i), 32'(stall_dec), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d wb0_ready", i), 32'(wb0_ready), 32'(vecs[i].e_r0));
      chk($sformatf("vec%0d wb1_ready", i), 32'(wb1_ready), 32'(vecs[i].e_r1));
      chk($sformatf("vec%0d rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
      chk($sformatf("vec%0d rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].e_waddr));
      if (vecs[i].e_we) chk($sformatf("vec%0d rf_wdata", i), rf_wdata, vecs[i].e_wdata);
      chk($sformatf("vec%0d busy_vec", i), busy_vec, vecs[i].e_busy);
      step();
    end
    idle();

    // RAW on x3: stall through the commit cycle unless forwarded
    issue(1, 3, 0, 0, 0, 0);
    @(negedge clk); chk("raw issue rd3", 32'(stall_dec), 32'd0);
    step();
    issue(0, 0, 1, 3, 0, 0);
    @(negedge clk); chk("raw stall busy", 32'(stall_dec), 32'd1);
    chk("raw busy_vec", busy_vec, 32'h8);
    step();
    wb1_valid = 1; wb1_rd = 3; wb1_data = 32'hCAFE0003;
    @(negedge clk); chk("raw stall wbreq", 32'(stall_dec), 32'd1);
    chk("raw wb1_ready", 32'(wb1_ready), 32'd1);
    step();
    wb1_valid = 0;
    @(negedge clk); chk("raw rf_waddr", 32'(rf_waddr), 32'd3);
`ifdef REGFILE_WB_BYPASS_EN
    chk("raw stall commit", 32'(stall_dec), 32'd0);
    chk("raw fwd_hit_p0", 32'(fwd_hit_p0), 32'd1);
    chk("raw fwd_data", fwd_data, 32'hCAFE0003);
`else
    chk("raw stall commit", 32'(stall_dec), 32'd1);
`endif
    step();
    @(negedge clk); chk("raw stall released", 32'(stall_dec), 32'd0);
    chk("raw busy cleared", busy_vec, 32'h0);
    step();
    idle();

    // Port conflict: read of a non-busy register being written this cycle
    wb0_valid = 1; wb0_rd = 12; wb0_data = 32'h0C0C0C0C;
    step();
    wb0_valid = 0;
    issue(0, 0, 0, 0, 1, 12);
    @(negedge clk); chk("port rf_we", 32'(rf_we), 32'd1);
`ifdef REGFILE_WB_BYPASS_EN
    chk("port stall", 32'(stall_dec), 32'd0);
    chk("port fwd_hit_p1", 32'(fwd_hit_p1), 32'd1);
`else
    chk("port stall", 32'(stall_dec), 32'd1);
`endif
    step();
    @(negedge clk); chk("port stall released", 32'(stall_dec), 32'd0);
    step();
    idle();

    // WAW on x4, then same-cycle set/clear of x6
    issue(1, 4, 0, 0, 0, 0);
    @(negedge clk); chk("waw first", 32'(stall_dec), 32'd0);
    step();
    wb0_valid = 1; wb0_rd = 4; wb0_data = 32'h44;
    @(negedge clk); chk("waw second stalls", 32'(stall_dec), 32'd1);
    step();
    wb0_valid = 0;
    @(negedge clk); chk("waw stall commit", 32'(stall_dec), 32'd1);
    chk("waw rf_waddr", 32'(rf_waddr), 32'd4);
    step();
    @(negedge clk); chk("waw accepted", 32'(stall_dec), 32'd0);
    chk("waw busy clear", busy_vec, 32'h0);
    step();
    idle();
    wb0_valid = 1; wb0_rd = 6; wb0_data = 32'h6;
    @(negedge clk); chk("waw busy reset4", busy_vec, 32'h10);
    step();
    idle();
    issue(1, 6, 0, 0, 0, 0);
    wb1_valid = 1; wb1_rd = 4; wb1_data = 32'h4;
    @(negedge clk); chk("setwin no stall", 32'(stall_dec), 32'd0);
    chk("setwin rf_waddr", 32'(rf_waddr), 32'd6);
    step();
    idle();
    @(negedge clk); chk("setwin busy", busy_vec, 32'h50);
    step();
    wb0_valid = 1; wb0_rd = 6; wb0_data = 32'h6;
    @(negedge clk); chk("setwin x4 retired", busy_vec, 32'h40);
    step();
    idle();
    step();
    @(negedge clk); chk("setwin x6 retired", busy_vec, 32'h0);
    step();

    // Reset mid-flight with busy_vec=0x28 and a pending write
    issue(1, 3, 0, 0, 0, 0);
    step();
    issue(1, 5, 0, 0, 0, 0);
    step();
    idle();
    wb0_valid = 1; wb0_rd = 8; wb0_data = 32'h88;
    wb1_valid = 1; wb1_rd = 9; wb1_data = 32'h99;
    @(negedge clk); chk("rst pre busy", busy_vec, 32'h28);
    chk("rst pre grant alu", 32'(wb0_ready), 32'd1);
    step();
    reset = 1;
    @(negedge clk); chk("rst pre rf_we", 32'(rf_we), 32'd1);
    step();
    reset = 0;
    @(negedge clk); chk("rst busy_vec", busy_vec, 32'h0);
    chk("rst rf_we", 32'(rf_we), 32'd0);
    chk("rst rr_ptr alu", 32'(wb0_ready), 32'd1);
    chk("rst rr_ptr lsu", 32'(wb1_ready), 32'd0);
    step();
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
